temperature_abnormality_detector: RTL and testbench

Converts a raw 4-bit sensor reading into a calibrated temperature using per-unit factory base and coefficient values. Flags low, high and combined temperature abnormality. Sits between the sensor interface and the alarm/monitor logic. Fully synchronous two-stage pipeline on one clock.

---
 rtl/temperature_abnormality_detector.sv | 76 +++++++
 tb/tb_temperature_abnormality_detector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/temperature_abnormality_detector.sv
// Two-stage pipeline: calibrates a raw sensor reading, then flags low/high temperature.
// Define TEMP_ABN_STICKY_EN to hold each flag until a clearAlarm cycle.
module temperature_abnormality_detector #(
    parameter int LOW_LIMIT  = 35,
    parameter int HIGH_LIMIT = 39
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] factotyBaseTemp,
    input  logic [3:0] factotyTempCoef,
    input  logic [3:0] tempSensorValue,
    input  logic       clearAlarm,
    output logic [5:0] tempValue,
    output logic       lowTempAbnormality,
    output logic       highTempAbnormality,
    output logic       tempAbnormality
);

    localparam logic [5:0] LowLimit  = 6'(LOW_LIMIT);
    localparam logic [5:0] HighLimit = 6'(HIGH_LIMIT);

    logic [7:0] product;
    logic [5:0] tempValue_d, tempValue_q;
    logic       valid_d, valid_q;
    logic       lowLive, highLive;
    logic       low_d, low_q;
    logic       high_d, high_q;
    logic       abn_d, abn_q;

    always_comb begin
        product     = {4'b0, factotyTempCoef} * {4'b0, tempSensorValue};
        tempValue_d = {1'b0, factotyBaseTemp} + 6'(product >> 4);
        valid_d     = 1'b1;
    end

    // valid_q keeps the flags at 0 until stage 1 holds a real sample after reset.
    always_comb begin
        lowLive  = valid_q && (tempValue_q < LowLimit);
        highLive = valid_q && (tempValue_q > HighLimit);
`ifdef TEMP_ABN_STICKY_EN
        low_d    = lowLive  | (low_q  & ~clearAlarm);
        high_d   = highLive | (high_q & ~clearAlarm);
`else
        low_d    = lowLive;
        high_d   = highLive;
`endif
        abn_d    = low_d | high_d;
    end

`ifndef TEMP_ABN_STICKY_EN
    logic unusedClearAlarm;
    assign unusedClearAlarm = clearAlarm;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tempValue_q <= '0;
            valid_q     <= 1'b0;
            low_q       <= 1'b0;
            high_q      <= 1'b0;
            abn_q       <= 1'b0;
        end else begin
            tempValue_q <= tempValue_d;
            valid_q     <= valid_d;
            low_q       <= low_d;
            high_q      <= high_d;
            abn_q       <= abn_d;
        end
    end

    assign tempValue           = tempValue_q;
    assign lowTempAbnormality  = low_q;
    assign highTempAbnormality = high_q;
    assign tempAbnormality     = abn_q;

endmodule

// File: tb/tb_temperature_abnormality_detector.sv
// Scoreboard bench for temperature_abnormality_detector: the driver pushes the expected
// outputs for each clock edge, a monitor pops and compares them after that edge.
module tb_temperature_abnormality_detector;

    typedef struct {
        logic [5:0] temp;
        logic       low;
        logic       high;
        logic       abn;
        int         tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] factotyBaseTemp;
    logic [3:0] factotyTempCoef;
    logic [3:0] tempSensorValue;
    logic       clearAlarm;
    logic [5:0] tempValue;
    logic       lowTempAbnormality;
    logic       highTempAbnormality;
    logic       tempAbnormality;

    int   checks   = 0;
    int   failures = 0;
    int   vecTag   = 0;
    exp_t expQ[$];

    // Reference model state: previous vector's hand-derived live flags and the held flags.
    logic mPrevValid = 1'b0;
    logic mPrevLow   = 1'b0;
    logic mPrevHigh  = 1'b0;
    logic mLow       = 1'b0;
    logic mHigh      = 1'b0;

    temperature_abnormality_detector dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .factotyBaseTemp     (factotyBaseTemp),
        .factotyTempCoef     (factotyTempCoef),
        .tempSensorValue     (tempSensorValue),
        .clearAlarm          (clearAlarm),
        .tempValue           (tempValue),
        .lowTempAbnormality  (lowTempAbnormality),
        .highTempAbnormality (highTempAbnormality),
        .tempAbnormality     (tempAbnormality)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check in the bench goes through here.
    task automatic checkOutput(input string name, input int tag, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s vec=%0d actual=%0d expected=%0d", name, tag, actual, expected);
        end
    endtask

    // Drive one vector at the falling edge (also releasing reset if held) and push the
    // outputs expected right after the next rising edge. expT/expLow/expHigh are the
    // hand-computed calibrated value and live compare results for this vector.
    task automatic applyStimulus(input logic [4:0] base, input logic [3:0] coef,
                                 input logic [3:0] sensor, input logic clr,
                                 input logic [5:0] expT, input logic expLow, input logic expHigh);
        exp_t rec;
        logic low;
        logic high;
        @(negedge clk);
        rst_n           = 1'b1;
        factotyBaseTemp = base;
        factotyTempCoef = coef;
        tempSensorValue = sensor;
        clearAlarm      = clr;
        low  = mPrevValid & mPrevLow;
        high = mPrevValid & mPrevHigh;
`ifdef TEMP_ABN_STICKY_EN
        low  = low  | (mLow  & ~clr);
        high = high | (mHigh & ~clr);
`endif
        rec.temp = expT;
        rec.low  = low;
        rec.high = high;
        rec.abn  = low | high;
        rec.tag  = vecTag;
        expQ.push_back(rec);
        vecTag++;
        mLow       = low;
        mHigh      = high;
        mPrevValid = 1'b1;
        mPrevLow   = expLow;
        mPrevHigh  = expHigh;
    endtask

    // Assert reset mid-cycle, confirm outputs clear without waiting for an edge, hold it
    // for two edges; the next applyStimulus releases it.
    task automatic doReset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_tempValue", vecTag, int'(tempValue), 0);
        checkOutput("rst_low", vecTag, int'(lowTempAbnormality), 0);
        checkOutput("rst_high", vecTag, int'(highTempAbnormality), 0);
        checkOutput("rst_abn", vecTag, int'(tempAbnormality), 0);
        mPrevValid = 1'b0;
        mPrevLow   = 1'b0;
        mPrevHigh  = 1'b0;
        mLow       = 1'b0;
        mHigh      = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    // Monitor: 3 time units after each rising edge, compare against the queued record.
    initial begin
        exp_t rec;
        forever begin
            @(posedge clk);
            #3;
            if (rst_n && expQ.size() > 0) begin
                rec = expQ.pop_front();
                checkOutput("tempValue", rec.tag, int'(tempValue), int'(rec.temp));
                checkOutput("low", rec.tag, int'(lowTempAbnormality), int'(rec.low));
                checkOutput("high", rec.tag, int'(highTempAbnormality), int'(rec.high));
                checkOutput("abn", rec.tag, int'(tempAbnormality), int'(rec.abn));
            end
        end
    end

    // Main directed sequence.
    initial begin
        rst_n           = 1'b0;
        factotyBaseTemp = 5'd0;
        factotyTempCoef = 4'd0;
        tempSensorValue = 4'd0;
        clearAlarm      = 1'b0;
        #1;
        checkOutput("init_tempValue", 0, int'(tempValue), 0);
        checkOutput("init_abn", 0, int'(tempAbnormality), 0);

        // Calibration and boundary vectors: base, coef, sensor, clr, T, low, high.
        applyStimulus(5'd25, 4'd4,  4'd5,  1'b0, 6'd26, 1'b1, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd31, 4'd8,  4'd8,  1'b0, 6'd35, 1'b0, 1'b0);
        applyStimulus(5'd31, 4'd15, 4'd15, 1'b0, 6'd45, 1'b0, 1'b1);
        applyStimulus(5'd31, 4'd8,  4'd7,  1'b0, 6'd34, 1'b1, 1'b0);
        applyStimulus(5'd27, 4'd14, 4'd15, 1'b0, 6'd40, 1'b0, 1'b1);
        applyStimulus(5'd30, 4'd9,  4'd9,  1'b0, 6'd35, 1'b0, 1'b0);
        applyStimulus(5'd0,  4'd0,  4'd0,  1'b0, 6'd0,  1'b1, 1'b0);
        applyStimulus(5'd20, 4'd15, 4'd14, 1'b0, 6'd33, 1'b1, 1'b0);

        // Back-to-back low -> normal -> high, then reset while high input is present.
        applyStimulus(5'd25, 4'd4,  4'd5,  1'b0, 6'd26, 1'b1, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd31, 4'd15, 4'd15, 1'b0, 6'd45, 1'b0, 1'b1);
        doReset();

        // After release the flags stay clear for the first edge, then follow the data.
        applyStimulus(5'd31, 4'd15, 4'd15, 1'b0, 6'd45, 1'b0, 1'b1);
        applyStimulus(5'd31, 4'd8,  4'd7,  1'b0, 6'd34, 1'b1, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);

        // Hold/clear sequence: single high pulse, normal data, clear; then persistent high
        // with clear pulses. Without the sticky build clearAlarm must have no effect.
        applyStimulus(5'd31, 4'd15, 4'd15, 1'b0, 6'd45, 1'b0, 1'b1);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b1, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd31, 4'd15, 4'd15, 1'b0, 6'd45, 1'b0, 1'b1);
        applyStimulus(5'd31, 4'd15, 4'd15, 1'b0, 6'd45, 1'b0, 1'b1);
        applyStimulus(5'd31, 4'd15, 4'd15, 1'b1, 6'd45, 1'b0, 1'b1);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b1, 6'd39, 1'b0, 1'b0);
        applyStimulus(5'd25, 4'd15, 4'd15, 1'b0, 6'd39, 1'b0, 1'b0);

        // Bounded drain of the scoreboard.
        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #4;
        checkOutput("drain_pending", vecTag, expQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
